// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I descriptor-to-word encoder feeding instruction memory
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mem_we_q, err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [31:0]         enc_word;
    logic                fmt_legal;
    logic                beat;

    // B/J immediates arrive as byte offsets; bit 0 is implied zero and dropped.
    always_comb begin
        enc_word  = '0;
        fmt_legal = 1'b1;
        case (fmt)
            3'b000: enc_word = {imm[11:0], rs1, func3, rd, opcode};
            3'b001: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            3'b010: enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            3'b011: enc_word = {imm[31:12], rd, opcode};
            3'b100: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            3'b101: enc_word = {func7, rs2, rs1, func3, rd, opcode};
            default: fmt_legal = 1'b0;
        endcase
    end

    assign in_ready = (state_q == ACTIVE) && !start && !finish;
    assign beat     = in_valid && in_ready;
    assign ptr_d    = ptr_q + ADDR_W'(1);
    assign count_d  = count_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            if (start) begin
                state_q <= ACTIVE;
                ptr_q   <= base_addr;
                count_q <= '0;
            end else if (finish) begin
                state_q <= IDLE;
            end else if (beat) begin
                if (fmt_legal) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= enc_word;
                    ptr_q       <= ptr_d;
                    count_q     <= count_d;
                    if (count_d == (ADDR_W+1)'(DEPTH))
                        state_q <= FULL;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = (state_q == FULL);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a field-level reference model
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, finish, in_valid;
    logic [ADDR_W-1:0] base_addr;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full, err;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement by shift-and-mask straight from the RV32I layout tables.
    function automatic logic [31:0] enc(input logic [2:0] f, input logic [31:0] op, input logic [31:0] d,
                                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] f3,
                                        input logic [31:0] f7, input logic [31:0] im);
        logic [31:0] base;
        base = op | (f3 << 12) | (s1 << 15);
        case (f)
            3'd0: return base | (d << 7) | ((im & 32'hFFF) << 20);
            3'd1: return base | (s2 << 20) | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
            3'd2: return base | (s2 << 20) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7)
                         | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
            3'd3: return op | (d << 7) | (im & 32'hFFFFF000);
            3'd4: return op | (d << 7) | (im & 32'h000FF000) | (((im >> 11) & 32'h1) << 20)
                         | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
            3'd5: return base | (d << 7) | (s2 << 20) | (f7 << 25);
            default: return 32'h0;
        endcase
    endfunction

    logic              m_act, m_full, m_we, m_err;
    logic [ADDR_W-1:0] m_ptr, m_addr;
    logic [31:0]       m_data;
    logic [ADDR_W:0]   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_full <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
            m_ptr <= '0; m_addr <= '0; m_data <= '0; m_cnt <= '0;
        end else begin
            m_we  <= 1'b0;
            m_err <= 1'b0;
            if (start) begin
                m_act <= 1'b1; m_full <= 1'b0; m_ptr <= base_addr; m_cnt <= '0;
            end else if (finish) begin
                m_act <= 1'b0; m_full <= 1'b0;
            end else if (in_valid && m_act && !m_full) begin
                if (fmt > 3'd5) begin
                    m_err <= 1'b1;
                end else begin
                    m_we   <= 1'b1;
                    m_addr <= m_ptr;
                    m_data <= enc(fmt, 32'(opcode), 32'(rd), 32'(rs1), 32'(rs2), 32'(func3), 32'(func7), imm);
                    m_ptr  <= ADDR_W'((32'(m_ptr) + 1) % (1 << ADDR_W));
                    m_cnt  <= m_cnt + 1'b1;
                    if (32'(m_cnt) + 1 == DEPTH) m_full <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_we", 32'(mem_we), 32'(m_we));
        chk("m_addr", 32'(mem_addr), 32'(m_addr));
        chk("m_wdata", mem_wdata, m_data);
        chk("m_count", 32'(count), 32'(m_cnt));
        chk("m_full", 32'(full), 32'(m_full));
        chk("m_err", 32'(err), 32'(m_err));
        chk("m_in_ready", 32'(in_ready), 32'(m_act && !m_full && !start && !finish));
    end

    task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic lit_write(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        chk({name, "_we"}, 32'(mem_we), 32'h1);
        chk({name, "_addr"}, 32'(mem_addr), 32'(a));
        chk({name, "_data"}, mem_wdata, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; base_addr = '0; in_valid = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; func3 = '0; func7 = '0; imm = '0;

        chk("enc_I", enc(3'd0, 32'h13, 1, 0, 0, 0, 0, 5), 32'h00500093);
        chk("enc_S", enc(3'd1, 32'h23, 0, 1, 2, 2, 0, 8), 32'h0020A423);
        chk("enc_B", enc(3'd2, 32'h63, 0, 1, 2, 0, 0, 8), 32'h00208463);
        chk("enc_J", enc(3'd4, 32'h6F, 1, 0, 0, 0, 0, 16), 32'h010000EF);
        chk("enc_R", enc(3'd5, 32'h33, 3, 1, 2, 0, 0, 0), 32'h002081B3);
        chk("enc_U", enc(3'd3, 32'h37, 5, 0, 0, 0, 0, 32'h12345000), 32'h123452B7);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pulse_start(8'h10);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        lit_write("I", 8'h10, 32'h00500093);
        chk("I_count", 32'(count), 1);
        beat(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        lit_write("S", 8'h11, 32'h0020A423);
        beat(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        lit_write("B", 8'h12, 32'h00208463);
        beat(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
        lit_write("J", 8'h13, 32'h010000EF);
        chk("J_full", 32'(full), 1);
        idle();

        pulse_start(8'h20);
        beat(3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        lit_write("R", 8'h20, 32'h002081B3);
        beat(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        lit_write("U", 8'h21, 32'h123452B7);
        beat(3'b110, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("ill_we", 32'(mem_we), 0);
        chk("ill_err", 32'(err), 1);
        chk("ill_count", 32'(count), 2);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        lit_write("after_ill", 8'h22, 32'h00500093);
        chk("after_ill_err", 32'(err), 0);
        idle();
        chk("idle_we", 32'(mem_we), 0);

        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        chk("fin_ready", 32'(in_ready), 0);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("fin_beat_we", 32'(mem_we), 0);
        idle();

        pulse_start(8'hFE);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        lit_write("wrap0", 8'hFE, 32'h00100093);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        lit_write("wrap1", 8'hFF, 32'h00200093);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        lit_write("wrap2", 8'h00, 32'h00300093);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        lit_write("wrap3", 8'h01, 32'h00400093);
        chk("wrap_full", 32'(full), 1);
        chk("wrap_ready", 32'(in_ready), 0);
        beat(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        chk("fifth_we", 32'(mem_we), 0);
        chk("fifth_count", 32'(count), 4);
        chk("fifth_full", 32'(full), 1);

        start = 1'b1; base_addr = 8'h30;
        #1;
        chk("start_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_we", 32'(mem_we), 0);
        chk("start_count", 32'(count), 0);
        chk("start_full", 32'(full), 0);
        @(posedge clk); #1;
        lit_write("post_start", 8'h30, 32'h00500093);

        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_data", mem_wdata, 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts field-level instruction descriptors (format, opcode, rd, rs1, rs2, func3, func7, immediate) over a valid/ready handshake.
- Packs each descriptor into a 32-bit RV32I word and writes it to consecutive instruction-memory word addresses.
- Serves as the program loader feeding the single-cycle core's instruction memory, in simulation and at bring-up.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, maximum words written per session; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: open session at base_addr, clear count.
- finish  input  1  one-cycle pulse: close session, return to IDLE.
- base_addr  input  ADDR_W  first word address of session, sampled on start.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder can accept descriptor this cycle.
- fmt  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110/111 illegal (same imm_type codes as decoder/sign extender).
- opcode  input  7  instruction[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- func3  input  3  funct3.
- func7  input  7  funct7 (R only).
- imm  input  32  immediate, byte-offset form for B/J, full upper value for U.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  words written this session.
- full  output  1  high in FULL state.
- err  output  1  one-cycle pulse: illegal fmt dropped.

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, write pointer=0; in_ready=0.
- States: IDLE, ACTIVE, FULL.
  - IDLE -start-> ACTIVE.
  - ACTIVE -DEPTH-th legal beat accepted-> FULL.
  - ACTIVE/FULL -finish-> IDLE.
  - start in any state -> ACTIVE: pointer=base_addr, count=0, full=0.
- Priority: rst_n > start > finish > data beat.
- in_ready = (state==ACTIVE) && !start && !finish (combinational). A beat transfers only when in_valid && in_ready.
- Latency: 1 cycle. On the transfer edge, register mem_we=1, mem_addr=pointer, mem_wdata=encoded word; mem_we is a one-cycle pulse, low otherwise.
- Data hold: mem_addr and mem_wdata hold their last values when idle.
- After a legal beat: pointer+1 modulo 2**ADDR_W (wraps silently), count+1.
- Illegal fmt: beat consumed, no write, pointer/count unchanged, err=1 for the following cycle.
- Encoding (op=opcode, f3=func3):
  - I: imm[11:0] | rs1 | f3 | rd | op.
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - U: imm[31:12] | rd | op.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
  - R: func7 | rs2 | rs1 | f3 | rd | op.
  - Unused fields are ignored; B/J imm[0] is discarded; imm bits above each format's range are ignored (no range check).
- FULL: in_ready=0, full=1, no writes; only start, finish, or reset leave FULL.
- finish/start on the same cycle as a pending write: the write registered on the previous edge still completes (mem_we pulse is not cancelled).
- Reset mid-session: everything is cleared immediately; any in-flight mem_we is dropped.

Test Plan:
- rst_n low, then start with base_addr=0x10, then I beat (op=0010011, rd=1, rs1=0, f3=0, imm=5) -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x00500093, count=1.
- Back-to-back beats, in_valid held high:
  - S (op=0100011, rs1=1, rs2=2, f3=010, imm=8) -> 0x0020A423.
  - B (op=1100011, rs1=1, rs2=2, f3=0, imm=8) -> 0x00208463.
  - J (op=1101111, rd=1, imm=16) -> 0x010000EF.
  - Addresses increment by 1 each cycle.
- R (op=0110011, rd=3, rs1=1, rs2=2, f3=0, func7=0) -> 0x002081B3. U (op=0110111, rd=5, imm=0x12345000) -> 0x123452B7.
- fmt=110 beat -> no mem_we, err pulse of one cycle, next legal beat lands on the unchanged address.
- DEPTH=4, base_addr=0xFE, 5 beats offered -> writes to 0xFE, 0xFF, 0x00, 0x01; then full=1, in_ready=0, 5th beat not accepted; start -> ACTIVE, count=0.
- start asserted together with in_valid -> beat not accepted. rst_n pulsed low mid-session -> all outputs return to reset values asynchronously.
